// File: rtl/sram_bus_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: two single-byte request/ack ports and shared read data.
interface sram_bus_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              REQ0;
    logic              WE0;
    logic [ADDR_W-1:0] ADDR0;
    logic [DATA_W-1:0] WDATA0;
    logic              ACK0;
    logic              REQ1;
    logic              WE1;
    logic [ADDR_W-1:0] ADDR1;
    logic [DATA_W-1:0] WDATA1;
    logic              ACK1;
    logic [DATA_W-1:0] RDATA;

    modport master (
        output REQ0, WE0, ADDR0, WDATA0,
        output REQ1, WE1, ADDR1, WDATA1,
        input  ACK0, ACK1, RDATA
    );

    modport slave (
        input  REQ0, WE0, ADDR0, WDATA0,
        input  REQ1, WE1, ADDR1, WDATA1,
        output ACK0, ACK1, RDATA
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-port arbiter and SETUP/ACCESS/HOLD strobe sequencer for a 32Kx8 asynchronous SRAM.
// Define SRAM_ARB_FIXED_PRIORITY_EN for fixed priority (port 0 wins); default is round-robin.
//   state  | meaning
//   IDLE   | strobes high, IO released, accepting a request
//   SETUP  | address and nCS asserted, write data driven
//   ACCESS | nOE or nWE low for ACCESS_CYCLES cycles
//   HOLD   | strobes high, address/data held, ACK pulsed
module sram_bus_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 15,
    parameter int DATA_W        = 8
) (
    input  logic              CLK,
    input  logic              nRESET,
    sram_bus_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] SRAM_A,
    output logic              SRAM_nCS,
    output logic              SRAM_nOE,
    output logic              SRAM_nWE,
    inout  wire  [DATA_W-1:0] SRAM_IO
);

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t            state;
    logic              grant_sel;
    logic              next_sel;
    logic              any_req;
    logic              lat_we;
    logic [3:0]        cnt;
    logic              io_oe;
    logic [DATA_W-1:0] io_out;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
    logic              last_grant;
`endif

    always_comb begin
        any_req = bus.REQ0 | bus.REQ1;
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
        next_sel = ~bus.REQ0;
`else
        if (bus.REQ0 && bus.REQ1)
            next_sel = ~last_grant;
        else
            next_sel = bus.REQ1;
`endif
    end

    assign SRAM_IO = io_oe ? io_out : 'z;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state     <= IDLE;
            grant_sel <= 1'b0;
            lat_we    <= 1'b0;
            cnt       <= '0;
            SRAM_A    <= '0;
            SRAM_nCS  <= 1'b1;
            SRAM_nOE  <= 1'b1;
            SRAM_nWE  <= 1'b1;
            io_oe     <= 1'b0;
            io_out    <= '0;
            bus.ACK0  <= 1'b0;
            bus.ACK1  <= 1'b0;
            bus.RDATA <= '0;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
            last_grant <= 1'b1;
`endif
        end else begin
            bus.ACK0 <= 1'b0;
            bus.ACK1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_sel <= next_sel;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
                        last_grant <= next_sel;
`endif
                        lat_we   <= next_sel ? bus.WE1 : bus.WE0;
                        SRAM_A   <= next_sel ? bus.ADDR1 : bus.ADDR0;
                        io_out   <= next_sel ? bus.WDATA1 : bus.WDATA0;
                        io_oe    <= next_sel ? bus.WE1 : bus.WE0;
                        SRAM_nCS <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    cnt      <= CNT_LOAD;
                    SRAM_nOE <= lat_we;
                    SRAM_nWE <= ~lat_we;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        SRAM_nOE <= 1'b1;
                        SRAM_nWE <= 1'b1;
                        // read data is sampled while nOE is still low
                        if (!lat_we)
                            bus.RDATA <= SRAM_IO;
                        bus.ACK0 <= ~grant_sel;
                        bus.ACK1 <= grant_sel;
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    SRAM_nCS <= 1'b1;
                    io_oe    <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: SRAM model, reference memory and arbitration model.
module tb_sram_bus_arbiter;

    localparam int AC   = 2;
    localparam int AC_A = 1;
    localparam int AC_B = 15;
    localparam int AW   = 15;
    localparam int DW   = 8;

    logic CLK = 1'b0;
    logic nRESET;
    always #5 CLK = ~CLK;

    int tests_run = 0;
    int fails     = 0;

    function automatic logic [7:0] init_val(logic [14:0] a);
        return a[7:0] ^ {a[14:8], 1'b1};
    endfunction

    // main DUT
    sram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [AW-1:0] sram_a;
    logic          sram_ncs, sram_noe, sram_nwe;
    wire  [DW-1:0] sram_io;

    sram_bus_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .nRESET(nRESET), .bus(bus),
        .SRAM_A(sram_a), .SRAM_nCS(sram_ncs), .SRAM_nOE(sram_noe),
        .SRAM_nWE(sram_nwe), .SRAM_IO(sram_io)
    );

    logic [7:0] sram_mem [0:32767];
    bit         sram_wr  [0:32767];
    assign sram_io = (!sram_ncs && !sram_noe)
                   ? (sram_wr[sram_a] ? sram_mem[sram_a] : init_val(sram_a)) : 'z;
    always @(posedge CLK) begin
        if (!sram_ncs && !sram_nwe) begin
            sram_mem[sram_a] <= sram_io;
            sram_wr[sram_a]  <= 1'b1;
        end
    end

    // short and long access-time instances, read-only ROM-like models
    sram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    sram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();
    logic [AW-1:0] a_a, a_b;
    logic          ncs_a, noe_a, nwe_a, ncs_b, noe_b, nwe_b;
    wire  [DW-1:0] io_a, io_b;
    assign io_a = (!ncs_a && !noe_a) ? init_val(a_a) : 'z;
    assign io_b = (!ncs_b && !noe_b) ? init_val(a_b) : 'z;

    sram_bus_arbiter #(.ACCESS_CYCLES(AC_A), .ADDR_W(AW), .DATA_W(DW)) dut_a (
        .CLK(CLK), .nRESET(nRESET), .bus(bus_a),
        .SRAM_A(a_a), .SRAM_nCS(ncs_a), .SRAM_nOE(noe_a), .SRAM_nWE(nwe_a), .SRAM_IO(io_a)
    );
    sram_bus_arbiter #(.ACCESS_CYCLES(AC_B), .ADDR_W(AW), .DATA_W(DW)) dut_b (
        .CLK(CLK), .nRESET(nRESET), .bus(bus_b),
        .SRAM_A(a_b), .SRAM_nCS(ncs_b), .SRAM_nOE(noe_b), .SRAM_nWE(nwe_b), .SRAM_IO(io_b)
    );

    // pin monitor on the main DUT, sampled mid-cycle
    int noe_lo = 0, nwe_lo = 0, ncs_lo = 0, ncs_hi = 0, arb_drv = 0, bad_combo = 0;
    always @(negedge CLK) begin
        if (!sram_noe) noe_lo++;
        if (!sram_nwe) nwe_lo++;
        if (!sram_ncs) ncs_lo++; else ncs_hi++;
        if (sram_noe && sram_io !== '0) arb_drv++;
        if ((!sram_noe && !sram_nwe) || ((!sram_noe || !sram_nwe) && sram_ncs)) bad_combo++;
    end

    // reference model
    logic [7:0]    ref_mem [int];
    logic [7:0]    exp_rdata;
    int            exp_last;
    bit            cur_we [2];
    logic [AW-1:0] cur_a  [2];
    logic [DW-1:0] cur_d  [2];

    function automatic logic [7:0] ref_rd(logic [14:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    function automatic int exp_grant(bit r0, bit r1);
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
        return r0 ? 0 : 1;
`else
        if (r0 && r1) return (exp_last == 0) ? 1 : 0;
        return r0 ? 0 : 1;
`endif
    endfunction

    task automatic model_complete(input int e);
        if (cur_we[e]) ref_mem[int'(cur_a[e])] = cur_d[e];
        else           exp_rdata = ref_rd(cur_a[e]);
    endtask

    task automatic set_req(input int p, input bit r, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.REQ0 = r; bus.WE0 = we; bus.ADDR0 = a; bus.WDATA0 = d;
        end else begin
            bus.REQ1 = r; bus.WE1 = we; bus.ADDR1 = a; bus.WDATA1 = d;
        end
    endtask

    task automatic new_req(input int q);
        cur_we[q] = 1'($urandom_range(0, 1));
        cur_a[q]  = 15'($urandom_range(0, 15));
        cur_d[q]  = 8'($urandom_range(1, 255));
        set_req(q, 1'b1, cur_we[q], cur_a[q], cur_d[q]);
    endtask

    // p: 0/1 port acked, 2 both at once, -1 no ack within budget
    task automatic wait_ack(output int p, output int n);
        p = -1;
        n = 0;
        for (int i = 0; i < 40 && p < 0; i++) begin
            @(posedge CLK); #1;
            n++;
            if (bus.ACK0 && bus.ACK1) p = 2;
            else if (bus.ACK0)        p = 0;
            else if (bus.ACK1)        p = 1;
        end
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        tests_run++;
        if ({sram_ncs, sram_noe, sram_nwe} !== 3'b111)
            $display("FAIL reset_strobes: got %b expected 111", {sram_ncs, sram_noe, sram_nwe});
        if ({sram_ncs, sram_noe, sram_nwe} !== 3'b111) fails++;
        tests_run++;
        if (sram_a !== '0 || bus.ACK0 !== 1'b0 || bus.ACK1 !== 1'b0 || bus.RDATA !== '0) begin
            fails++;
            $display("FAIL reset_values: A=%h ACK0=%b ACK1=%b RDATA=%h expected all zero",
                     sram_a, bus.ACK0, bus.ACK1, bus.RDATA);
        end
        tests_run++;
        if (sram_io !== '0) begin
            fails++;
            $display("FAIL reset_io: got %h expected released", sram_io);
        end
        @(negedge CLK) nRESET = 1'b1;
        exp_last  = 1;
        exp_rdata = '0;
        repeat (2) @(posedge CLK);
        #1;
        tests_run++;
        if (sram_ncs !== 1'b1 || bus.ACK0 !== 1'b0 || bus.ACK1 !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: nCS=%b ACK0=%b ACK1=%b expected 1 0 0",
                     sram_ncs, bus.ACK0, bus.ACK1);
        end
    endtask

    task automatic test_port1_read();
        int p, n, s_drv, s_noe;
        @(negedge CLK);
        s_drv = arb_drv; s_noe = noe_lo;
        set_req(1, 1'b1, 1'b0, 15'h0000, 8'hC3);
        wait_ack(p, n);
        exp_rdata = ref_rd(15'h0000);
        exp_last  = 1;
        tests_run++;
        if (p !== 1 || n !== AC + 2) begin
            fails++;
            $display("FAIL p1_read_ack: port=%0d edges=%0d expected port=1 edges=%0d", p, n, AC + 2);
        end
        tests_run++;
        if (bus.RDATA !== exp_rdata) begin
            fails++;
            $display("FAIL p1_read_data: got %h expected %h", bus.RDATA, exp_rdata);
        end
        set_req(1, 1'b0, 1'b0, 15'h0000, 8'hC3);
        @(posedge CLK); #1;
        tests_run++;
        if (arb_drv - s_drv !== 0 || noe_lo - s_noe !== AC) begin
            fails++;
            $display("FAIL p1_read_pins: io_drive_cycles=%0d nOE_low=%0d expected 0 and %0d",
                     arb_drv - s_drv, noe_lo - s_noe, AC);
        end
    endtask

    task automatic test_write_read();
        int p, n, s_drv, s_noe, s_nwe, s_ncs;
        @(negedge CLK);
        s_drv = arb_drv; s_noe = noe_lo; s_nwe = nwe_lo; s_ncs = ncs_lo;
        set_req(0, 1'b1, 1'b1, 15'h1234, 8'hA5);
        wait_ack(p, n);
        exp_last = 0;
        ref_mem[32'h1234] = 8'hA5;
        tests_run++;
        if (p !== 0 || n !== AC + 2) begin
            fails++;
            $display("FAIL write_ack: port=%0d edges=%0d expected port=0 edges=%0d", p, n, AC + 2);
        end
        tests_run++;
        if (bus.RDATA !== exp_rdata) begin
            fails++;
            $display("FAIL write_keeps_rdata: got %h expected %h", bus.RDATA, exp_rdata);
        end
        set_req(0, 1'b0, 1'b1, 15'h1234, 8'hA5);
        @(posedge CLK); #1;
        tests_run++;
        if (nwe_lo - s_nwe !== AC || noe_lo - s_noe !== 0 ||
            arb_drv - s_drv !== AC + 2 || ncs_lo - s_ncs !== AC + 2) begin
            fails++;
            $display("FAIL write_pins: nWE_low=%0d nOE_low=%0d io_drive=%0d nCS_low=%0d expected %0d 0 %0d %0d",
                     nwe_lo - s_nwe, noe_lo - s_noe, arb_drv - s_drv, ncs_lo - s_ncs, AC, AC + 2, AC + 2);
        end

        @(negedge CLK);
        s_drv = arb_drv; s_noe = noe_lo; s_nwe = nwe_lo;
        set_req(0, 1'b1, 1'b0, 15'h1234, 8'h77);
        wait_ack(p, n);
        exp_last  = 0;
        exp_rdata = ref_rd(15'h1234);
        tests_run++;
        if (p !== 0 || n !== AC + 2) begin
            fails++;
            $display("FAIL read_ack: port=%0d edges=%0d expected port=0 edges=%0d", p, n, AC + 2);
        end
        tests_run++;
        if (bus.RDATA !== exp_rdata) begin
            fails++;
            $display("FAIL read_back: got %h expected %h", bus.RDATA, exp_rdata);
        end
        set_req(0, 1'b0, 1'b0, 15'h1234, 8'h77);
        @(posedge CLK); #1;
        tests_run++;
        if (noe_lo - s_noe !== AC || nwe_lo - s_nwe !== 0 || arb_drv - s_drv !== 0) begin
            fails++;
            $display("FAIL read_pins: nOE_low=%0d nWE_low=%0d io_drive=%0d expected %0d 0 0",
                     noe_lo - s_noe, nwe_lo - s_nwe, arb_drv - s_drv, AC);
        end
    endtask

    task automatic test_contention();
        int p, n, e, hi0;
        @(negedge CLK);
        new_req(0);
        new_req(1);
        hi0 = ncs_hi;
        for (int k = 0; k < 4; k++) begin
            e = exp_grant(1'b1, 1'b1);
            wait_ack(p, n);
            tests_run++;
            if (p !== e || n !== ((k == 0) ? AC + 2 : AC + 3)) begin
                fails++;
                $display("FAIL contention_grant[%0d]: port=%0d edges=%0d expected port=%0d edges=%0d",
                         k, p, n, e, (k == 0) ? AC + 2 : AC + 3);
            end
            if (k > 0) begin
                tests_run++;
                if (ncs_hi - hi0 < 1) begin
                    fails++;
                    $display("FAIL contention_gap[%0d]: nCS high cycles=%0d expected at least 1",
                             k, ncs_hi - hi0);
                end
            end
            hi0 = ncs_hi;
            exp_last = e;
            model_complete(e);
            tests_run++;
            if (bus.RDATA !== exp_rdata) begin
                fails++;
                $display("FAIL contention_rdata[%0d]: got %h expected %h", k, bus.RDATA, exp_rdata);
            end
            if (k < 3) new_req(e);
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        @(posedge CLK); #1;
    endtask

    task automatic test_random();
        int p, n, e, m;
        bit first;
        bit pend [2];
        for (int r = 0; r < 20; r++) begin
            m = $urandom_range(1, 3);
            @(negedge CLK);
            pend[0] = m[0];
            pend[1] = m[1];
            for (int q = 0; q < 2; q++) if (pend[q]) new_req(q);
            first = 1'b1;
            while (pend[0] || pend[1]) begin
                e = exp_grant(pend[0], pend[1]);
                wait_ack(p, n);
                tests_run++;
                if (p !== e || n !== (first ? AC + 2 : AC + 3)) begin
                    fails++;
                    $display("FAIL random_grant[%0d]: port=%0d edges=%0d expected port=%0d edges=%0d",
                             r, p, n, e, first ? AC + 2 : AC + 3);
                end
                exp_last = e;
                model_complete(e);
                tests_run++;
                if (bus.RDATA !== exp_rdata) begin
                    fails++;
                    $display("FAIL random_rdata[%0d]: got %h expected %h", r, bus.RDATA, exp_rdata);
                end
                pend[e] = 1'b0;
                set_req(e, 1'b0, cur_we[e], cur_a[e], cur_d[e]);
                first = 1'b0;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid();
        int p, n, acks;
        @(negedge CLK);
        set_req(0, 1'b1, 1'b1, 15'h0100, 8'h5A);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        tests_run++;
        if (sram_nwe !== 1'b0) begin
            fails++;
            $display("FAIL mid_in_access: nWE=%b expected 0", sram_nwe);
        end
        nRESET = 1'b0;
        #1;
        tests_run++;
        if (sram_nwe !== 1'b1 || sram_ncs !== 1'b1 || sram_io !== '0 || bus.ACK0 !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_release: nWE=%b nCS=%b IO=%h ACK0=%b expected 1 1 released 0",
                     sram_nwe, sram_ncs, sram_io, bus.ACK0);
        end
        set_req(0, 1'b0, 1'b1, 15'h0100, 8'h5A);
        acks = 0;
        repeat (2) begin
            @(posedge CLK); #1;
            if (bus.ACK0 || bus.ACK1) acks++;
        end
        @(negedge CLK) nRESET = 1'b1;
        exp_last  = 1;
        exp_rdata = '0;
        repeat (3) begin
            @(posedge CLK); #1;
            if (bus.ACK0 || bus.ACK1) acks++;
        end
        tests_run++;
        if (acks !== 0) begin
            fails++;
            $display("FAIL mid_reset_no_ack: acks=%0d expected 0", acks);
        end
        @(negedge CLK);
        set_req(1, 1'b1, 1'b0, 15'h0005, 8'h99);
        wait_ack(p, n);
        exp_last  = 1;
        exp_rdata = ref_rd(15'h0005);
        tests_run++;
        if (p !== 1 || n !== AC + 2 || bus.RDATA !== exp_rdata) begin
            fails++;
            $display("FAIL after_reset_read: port=%0d edges=%0d data=%h expected 1 %0d %h",
                     p, n, bus.RDATA, AC + 2, exp_rdata);
        end
        set_req(1, 1'b0, 1'b0, 15'h0005, 8'h99);
        @(posedge CLK); #1;
    endtask

    task automatic test_access_cycles();
        int na, nb, noea, noeb, n;
        na = 0; nb = 0; noea = 0; noeb = 0; n = 0;
        @(negedge CLK);
        bus_a.WE0 = 1'b0; bus_a.ADDR0 = 15'h0ABC; bus_a.WDATA0 = 8'h3C; bus_a.REQ0 = 1'b1;
        bus_b.WE0 = 1'b0; bus_b.ADDR0 = 15'h1357; bus_b.WDATA0 = 8'hC3; bus_b.REQ0 = 1'b1;
        while ((na == 0 || nb == 0) && n < 40) begin
            @(posedge CLK); #1;
            n++;
            if (!noe_a) noea++;
            if (!noe_b) noeb++;
            if (bus_a.ACK0 && na == 0) begin na = n; bus_a.REQ0 = 1'b0; end
            if (bus_b.ACK0 && nb == 0) begin nb = n; bus_b.REQ0 = 1'b0; end
        end
        tests_run++;
        if (na !== AC_A + 2 || noea !== AC_A) begin
            fails++;
            $display("FAIL ac1_timing: ack_edge=%0d nOE_low=%0d expected %0d %0d", na, noea, AC_A + 2, AC_A);
        end
        tests_run++;
        if (nb !== AC_B + 2 || noeb !== AC_B) begin
            fails++;
            $display("FAIL ac15_timing: ack_edge=%0d nOE_low=%0d expected %0d %0d", nb, noeb, AC_B + 2, AC_B);
        end
        tests_run++;
        if (bus_a.RDATA !== init_val(15'h0ABC) || bus_b.RDATA !== init_val(15'h1357)) begin
            fails++;
            $display("FAIL ac_rdata: got %h %h expected %h %h", bus_a.RDATA, bus_b.RDATA,
                     init_val(15'h0ABC), init_val(15'h1357));
        end
    endtask

    initial begin
        bus.REQ0 = 1'b0; bus.WE0 = 1'b0; bus.ADDR0 = '0; bus.WDATA0 = '0;
        bus.REQ1 = 1'b0; bus.WE1 = 1'b0; bus.ADDR1 = '0; bus.WDATA1 = '0;
        bus_a.REQ0 = 1'b0; bus_a.WE0 = 1'b0; bus_a.ADDR0 = '0; bus_a.WDATA0 = '0;
        bus_a.REQ1 = 1'b0; bus_a.WE1 = 1'b0; bus_a.ADDR1 = '0; bus_a.WDATA1 = '0;
        bus_b.REQ0 = 1'b0; bus_b.WE0 = 1'b0; bus_b.ADDR0 = '0; bus_b.WDATA0 = '0;
        bus_b.REQ1 = 1'b0; bus_b.WE1 = 1'b0; bus_b.ADDR1 = '0; bus_b.WDATA1 = '0;
        exp_last  = 1;
        exp_rdata = '0;

        test_reset();
        test_contention();
        test_port1_read();
        test_write_read();
        test_random();
        test_reset_mid();
        test_access_cycles();

        tests_run++;
        if (bad_combo !== 0) begin
            fails++;
            $display("FAIL strobe_rules: illegal strobe samples=%0d expected 0", bad_combo);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Two-port arbiter and cycle sequencer for the 32Kx8 asynchronous SRAM model (A[14:0], nCS, nOE, nWE, bidirectional IO[7:0]).
- Each requester issues single-byte read/write requests; the block grants one request at a time.
- For the granted request it drives a timed SETUP/ACCESS/HOLD strobe sequence on the SRAM pins and returns read data.
- Sits between the CPU-side bus (port 0) and the video/DMA fetch engine (port 1) in the emulator top level.

Parameters:
ACCESS_CYCLES, 2, number of cycles nOE/nWE is held low; legal range 1..15, 4-bit counter
ADDR_W, 15, SRAM address width
DATA_W, 8, SRAM data width

Ports:
CLK  in  1  system clock, all state on rising edge
nRESET  in  1  asynchronous active-low reset
REQ0  in  1  port 0 request; held high until ACK0
WE0  in  1  port 0 direction, 1=write 0=read; stable while REQ0
ADDR0  in  ADDR_W  port 0 address; stable while REQ0
WDATA0  in  DATA_W  port 0 write data; stable while REQ0
ACK0  out  1  one-cycle completion pulse for port 0
REQ1, WE1, ADDR1, WDATA1, ACK1  as port 0, for port 1
RDATA  out  DATA_W  read data of the last completed read; shared by both ports
SRAM_A  out  ADDR_W  SRAM address
SRAM_nCS  out  1  SRAM chip select, active low
SRAM_nOE  out  1  SRAM output enable, active low
SRAM_nWE  out  1  SRAM write enable, active low
SRAM_IO  inout  DATA_W  SRAM data bus; driven only during write SETUP/ACCESS/HOLD, otherwise high-Z

Behaviour:
- Clock and reset: one clock CLK; reset nRESET is asynchronous, active-low.
- Reset values: state=IDLE, SRAM_nCS/nOE/nWE=1, SRAM_A=0, SRAM_IO=Z, ACK0/ACK1=0, RDATA=0, last_grant=1 (port 0 wins the first contention).
- All SRAM outputs and ACKs are registered; no combinational path from REQ to pins.
- IDLE:
  - strobes high, IO high-Z.
  - On an edge with any REQ high: select a port, latch its WE/ADDR/WDATA, go to SETUP.
- Arbitration (default): round-robin. With both REQs high, grant the port != last_grant; with one REQ high, grant it. last_grant updates on acceptance.
- SETUP (1 cycle):
  - SRAM_A=latched addr, nCS=0, nOE=nWE=1.
  - Write: SRAM_IO driven with latched data.
  - Load counter with ACCESS_CYCLES-1, then go to ACCESS.
- ACCESS (ACCESS_CYCLES cycles):
  - nCS=0; read: nOE=0; write: nWE=0, IO still driven.
  - Counter decrements; at 0 go to HOLD.
  - Read: RDATA captures SRAM_IO on the edge leaving ACCESS.
- HOLD (1 cycle):
  - nOE=nWE=1, nCS=0, address held; write data still driven (hold time).
  - ACK of the granted port = 1 for this cycle only. Then go to IDLE.
- Latency: request accepted at edge e0 -> ACK high during cycle following edge e0+ACCESS_CYCLES+1. With default 2: ACK 3 edges after acceptance; total occupancy 4 cycles + 1 IDLE gap.
- Back-to-back: every transaction returns to IDLE for at least 1 cycle with nCS=1. Minimum period is ACCESS_CYCLES+3 cycles per transaction.
- Requester rules:
  - Sample ACK high, then drop REQ at that same edge or keep it high with new WE/ADDR/WDATA for the next request.
  - REQ seen high in IDLE is always a new request.
- REQ dropped before ACK: the transaction in flight completes anyway. ACK is still pulsed; the requester ignores it.
- RDATA: unchanged by writes; holds the last read value until the next read's ACCESS exit.
- nRESET asserted mid-transaction: strobes deassert and IO releases immediately (asynchronous). The transaction is abandoned with no ACK. For a write, SRAM contents at that address are undefined.
- Never nOE=0 and nWE=0 simultaneously. Never nOE/nWE low with nCS high.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority; port 0 always wins when both REQs are high. last_grant is unused, and port 1 may starve.
- Undefined: round-robin as above.

Test Plan:
- Port 0 write 0x1234<-0xA5, then port 0 read 0x1234 (ACCESS_CYCLES=2) -> nWE low exactly 2 cycles, ACK0 3 edges after acceptance, RDATA=0xA5 with ACK0 of the read.
- Port 1 reads 0x0000 after reset with no prior write -> RDATA equals model content, ACK1 only, ACK0 stays 0, IO never driven by arbiter.
- REQ0 and REQ1 both held high for 4 transactions from reset -> grant order 0,1,0,1; nCS high at least 1 cycle between each.
- With SRAM_ARB_FIXED_PRIORITY_EN, REQ0 and REQ1 held high for 3 transactions -> grants 0,0,0; ACK1 never asserted while REQ0 is high.
- nRESET pulled low during ACCESS of a write -> SRAM_nWE/nCS go 1 and SRAM_IO Z before the next CLK edge; no ACK; next request completes normally.
- ACCESS_CYCLES=1 and =15 builds, single read each -> nOE low 1 and 15 cycles respectively; ACK at edge e0+2 and e0+16.
